clk_cfg_sequencer: RTL and testbench
====================================

// Module: clk_cfg_sequencer
// PURPOSE
//  Upstream stage of the clock generator. Turns hub writes of the 8-bit CLK
//  register into a glitch-safe cfg[6:0] word for the clock muxes, plus a chip reset request.
//  Enable bits (PLLENA, OSCENA, OSCM) are applied first. CLKSEL changes only
//  after the sources they need have settled, so a mux never selects a dead source.
// PARAMETERS
//  OSC_SETTLE  1_000_000  clk_in cycles to wait after OSCENA 0->1 (10 ms at 100 MHz)
//  PLL_SETTLE  10_000     clk_in cycles to wait after PLLENA 0->1 (100 us)
//  RES_HOLD    16         clk_in cycles chip_res is held after a RESET-bit write
//  CNT_W       20         settle counter width; must hold max(OSC_SETTLE,PLL_SETTLE)
// PORTS
//  clk_in   in   1  free-running board clock; all logic on posedge
//  res      in   1  asynchronous, active-high reset
//  wr       in   1  one-cycle CLK-register write strobe, synchronous to clk_in
//  wdata    in   8  {RESET,PLLENA,OSCENA,OSCM1,OSCM0,CLKSEL[2:0]}
//  cfg      out  7  applied {PLLENA,OSCENA,OSCM1,OSCM0,CLKSEL}; feeds clock generator cfg
//  chip_res out  1  chip reset request; must not be looped back to res
//  busy     out  1  high whenever state != IDLE
//  clk_reg  out  8  readback: last accepted write with bit7 forced 0
// BEHAVIOUR
//  Reset (res=1, async): cfg=7'h00 (RCFAST), chip_res=0, busy=0, clk_reg=0,
//   state=IDLE, pending buffer cleared, counter=0.
//  States: IDLE, OSC_WAIT, PLL_WAIT, APPLY, RES_HOLD.
//  IDLE, wr with wdata[7]=1: go to RES_HOLD; chip_res=1 from the next cycle for RES_HOLD
//   cycles, then cfg=0, chip_res=0, back to IDLE. Writes during RES_HOLD are ignored.
//  IDLE, wr with wdata[7]=0 (new=N, current=C):
//   - Illegal select: N.CLKSEL>=3 needs OSCENA&PLLENA; CLKSEL==2 needs OSCENA.
//     If the required enable is missing, CLKSEL is forced to 3'b000 before anything else.
//   - Rising enable (OSCENA or PLLENA 0->1): on the next edge cfg[6:3] takes N's
//     enable/mode bits and CLKSEL stays at C. Then:
//     OSC_WAIT when OSCENA rose, followed by PLL_WAIT when PLLENA rose.
//     If only PLLENA rose, go straight to PLL_WAIT.
//     Each wait loads the counter with its settle value minus 1 and decrements to 0.
//     The state after the last wait is APPLY.
//   - APPLY: cfg[2:0]=N.CLKSEL; next state IDLE. One cycle.
//   - No rising enable: CLKSEL and the mode bits update on the next edge (latency 1).
//     Falling enables update one cycle later via APPLY, so a source is never deselected and disabled in the same edge.
//  wr while busy (not RES_HOLD): captured in a one-deep pending buffer; last write wins.
//   The pending write is processed from IDLE on the cycle after the current sequence ends.
//  wr on the cycle APPLY completes: treated as pending, same rule.
//  Settle is skipped when the enable is already 1 in C, even if it was toggled in a pending write.
//  clk_reg updates on every accepted wr (including pending), bit7 always 0.
//  Counter never wraps: it saturates at 0 and a wait exits on 0.
// CONFIGURATION
//  CLKSEQ_FAST_SIM_EN defined: OSC_SETTLE and PLL_SETTLE are both overridden to 16
//   and the RES_HOLD parameter is unchanged. This is for simulation and for bring-up bitstreams.
//  Not defined: the parameter values are used as given.
// STRUCTURE
//  Package clk_cfg_pkg:
//   - seq_state_t enum
//   - bit-index localparams (RESET_B=7, PLLENA_B=6, OSCENA_B=5, OSCM_B=4:3, CLKSEL_B=2:0)
//   - CLKSEL encodings: RCFAST=0, RCSLOW=1, XINPUT=2, PLLX1..PLLX16=3..7
//   - function legal_sel(cfg) returning the forced CLKSEL
//  Sub-module settle_timer: loadable CNT_W-bit down-counter with load, value and done.
//   Instantiated once; OSC_WAIT and PLL_WAIT share it.
// TESTING (all with CLKSEQ_FAST_SIM_EN)
//  1. After reset, write 8'h02 (XINPUT, no OSCENA) -> cfg=7'h00 next cycle (forced RCFAST), busy=0.
//  2. Write 8'h6F from cfg=0 -> next cycle cfg=7'h68 and busy=1; after 32 cycles
//     (16 OSC + 16 PLL) plus APPLY, cfg=7'h6F and busy=0.
//  3. From cfg=7'h6F, write 8'h01 -> cfg=7'h69 next cycle, then 7'h01 one cycle later.
//     No cycle may show CLKSEL>=3 with PLLENA=0.
//  4. During the OSC_WAIT of test 2, write 8'h6E then 8'h6D -> only 8'h6D is applied after
//     the sequence, with no extra settle. clk_reg=8'h6D.
//  5. Write 8'h80 -> chip_res high for exactly 16 cycles, then cfg=0.
//     A wr of 8'h6F during the hold is ignored.
//  6. Assert res mid OSC_WAIT with a pending write present -> all outputs reset
//     asynchronously and the pending write is never applied.

Source files
------------

// File: rtl/clk_cfg_pkg.sv
// Shared types, CLK-register bit positions, CLKSEL encodings and the select legality helper
// for the clock configuration sequencer.
package clk_cfg_pkg;

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_OSC_WAIT = 3'd1;
  localparam logic [2:0] S_PLL_WAIT = 3'd2;
  localparam logic [2:0] S_APPLY    = 3'd3;
  localparam logic [2:0] S_RES_HOLD = 3'd4;

  typedef enum logic [2:0] {
    ST_IDLE     = S_IDLE,
    ST_OSC_WAIT = S_OSC_WAIT,
    ST_PLL_WAIT = S_PLL_WAIT,
    ST_APPLY    = S_APPLY,
    ST_RES_HOLD = S_RES_HOLD
  } seq_state_t;

  localparam int RESET_B     = 7;
  localparam int PLLENA_B    = 6;
  localparam int OSCENA_B    = 5;
  localparam int OSCM_B_HI   = 4;
  localparam int OSCM_B_LO   = 3;
  localparam int CLKSEL_B_HI = 2;
  localparam int CLKSEL_B_LO = 0;

  localparam logic [2:0] SEL_RCFAST = 3'd0;
  localparam logic [2:0] SEL_RCSLOW = 3'd1;
  localparam logic [2:0] SEL_XINPUT = 3'd2;
  localparam logic [2:0] SEL_PLLX1  = 3'd3;
  localparam logic [2:0] SEL_PLLX2  = 3'd4;
  localparam logic [2:0] SEL_PLLX4  = 3'd5;
  localparam logic [2:0] SEL_PLLX8  = 3'd6;
  localparam logic [2:0] SEL_PLLX16 = 3'd7;

  // A select whose source is not enabled in the same word falls back to RCFAST.
  function automatic logic [2:0] legal_sel(input logic [6:0] c);
    logic [2:0] sel;
    sel = c[CLKSEL_B_HI:CLKSEL_B_LO];
    if (sel >= SEL_PLLX1) begin
      legal_sel = (c[OSCENA_B] & c[PLLENA_B]) ? sel : SEL_RCFAST;
    end else if (sel == SEL_XINPUT) begin
      legal_sel = c[OSCENA_B] ? sel : SEL_RCFAST;
    end else begin
      legal_sel = sel;
    end
  endfunction

endpackage

// File: rtl/settle_timer.sv
// Loadable down-counter shared by the oscillator/PLL settle waits and the reset hold.
// Saturates at zero; done is high while the count is zero.
module settle_timer #(
  parameter int CNT_W = 20
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic [CNT_W-1:0] value,
  output logic             done
);

  logic [CNT_W-1:0] value_r;

  // Load has priority; otherwise count down and stick at zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      value_r <= '0;
    end else if (load) begin
      value_r <= load_val;
    end else if (value_r != '0) begin
      value_r <= value_r - CNT_W'(1);
    end else begin
      value_r <= value_r;
    end
  end

  assign value = value_r;
  assign done  = (value_r == '0);

endmodule

// File: rtl/clk_cfg_sequencer.sv
// Sequences CLK-register writes into a glitch-safe clock-mux configuration and a chip reset request.
// Build option CLKSEQ_FAST_SIM_EN shortens both settle waits to 16 cycles.
module clk_cfg_sequencer
  import clk_cfg_pkg::*;
#(
  parameter int OSC_SETTLE = 1_000_000,
  parameter int PLL_SETTLE = 10_000,
  parameter int RES_HOLD   = 16,
  parameter int CNT_W      = 20
) (
  input  logic       clk_in,
  input  logic       res,
  input  logic       wr,
  input  logic [7:0] wdata,
  output logic [6:0] cfg,
  output logic       chip_res,
  output logic       busy,
  output logic [7:0] clk_reg
);

`ifdef CLKSEQ_FAST_SIM_EN
  localparam int OSC_EFF = 16;
  localparam int PLL_EFF = 16;
`else
  localparam int OSC_EFF = OSC_SETTLE;
  localparam int PLL_EFF = PLL_SETTLE;
`endif

  localparam logic [CNT_W-1:0] OSC_LOAD  = CNT_W'((OSC_EFF > 0) ? OSC_EFF - 1 : 0);
  localparam logic [CNT_W-1:0] PLL_LOAD  = CNT_W'((PLL_EFF > 0) ? PLL_EFF - 1 : 0);
  localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'((RES_HOLD > 0) ? RES_HOLD - 1 : 0);

  seq_state_t       state_r, state_nxt_s;
  logic [6:0]       cfg_r, cfg_nxt_s, tgt_r, tgt_nxt_s, n_cfg_s;
  logic             pll_after_r, pll_after_nxt_s, chip_res_r, chip_res_nxt_s, busy_r;
  logic [7:0]       clk_reg_r, pend_data_r, cmd_s;
  logic             pend_valid_r, pend_valid_nxt_s, cmd_valid_s, accept_s;
  logic             osc_rise_s, pll_rise_s, fall_s, tmr_load_s, tmr_done_s;
  logic [CNT_W-1:0] tmr_val_s, tmr_value_s;

  assign accept_s    = wr & (state_r != ST_RES_HOLD);
  assign cmd_valid_s = pend_valid_r | wr;
  assign cmd_s       = pend_valid_r ? pend_data_r : wdata;
  assign n_cfg_s     = {cmd_s[PLLENA_B:OSCM_B_LO], legal_sel(cmd_s[6:0])};
  assign osc_rise_s  = n_cfg_s[OSCENA_B] & ~cfg_r[OSCENA_B];
  assign pll_rise_s  = n_cfg_s[PLLENA_B] & ~cfg_r[PLLENA_B];
  assign fall_s      = (~n_cfg_s[OSCENA_B] & cfg_r[OSCENA_B]) | (~n_cfg_s[PLLENA_B] & cfg_r[PLLENA_B]);
  // In IDLE a pending word is consumed, so only a same-cycle write stays pending.
  assign pend_valid_nxt_s = (state_r == ST_RES_HOLD) ? pend_valid_r :
                            (state_r == ST_IDLE)     ? (pend_valid_r & wr) : (pend_valid_r | wr);

  settle_timer #(.CNT_W(CNT_W)) u_timer (
    .clk      (clk_in),
    .rst      (res),
    .load     (tmr_load_s),
    .load_val (tmr_val_s),
    .value    (tmr_value_s),
    .done     (tmr_done_s)
  );

  // Next-state and next-output decode for the sequencer.
  always_comb begin
    state_nxt_s     = state_r;
    cfg_nxt_s       = cfg_r;
    tgt_nxt_s       = tgt_r;
    pll_after_nxt_s = pll_after_r;
    chip_res_nxt_s  = chip_res_r;
    tmr_load_s      = 1'b0;
    tmr_val_s       = '0;
    case (state_r)
      ST_IDLE: begin
        if (!cmd_valid_s) begin
          cfg_nxt_s = cfg_r;
        end else if (cmd_s[RESET_B]) begin
          state_nxt_s    = ST_RES_HOLD;
          chip_res_nxt_s = 1'b1;
          tmr_load_s     = 1'b1;
          tmr_val_s      = HOLD_LOAD;
        end else if (osc_rise_s | pll_rise_s) begin
          // Enables only ever turn on here; the old select keeps its source until APPLY.
          cfg_nxt_s       = {n_cfg_s[6:5] | cfg_r[6:5], n_cfg_s[4:3], cfg_r[2:0]};
          tgt_nxt_s       = n_cfg_s;
          pll_after_nxt_s = osc_rise_s & pll_rise_s;
          tmr_load_s      = 1'b1;
          if (osc_rise_s) begin
            state_nxt_s = ST_OSC_WAIT;
            tmr_val_s   = OSC_LOAD;
          end else begin
            state_nxt_s = ST_PLL_WAIT;
            tmr_val_s   = PLL_LOAD;
          end
        end else if (fall_s) begin
          cfg_nxt_s   = {cfg_r[6:3], n_cfg_s[2:0]};
          tgt_nxt_s   = n_cfg_s;
          state_nxt_s = ST_APPLY;
        end else begin
          cfg_nxt_s = n_cfg_s;
        end
      end
      ST_OSC_WAIT: begin
        if (!tmr_done_s) begin
          state_nxt_s = ST_OSC_WAIT;
        end else if (pll_after_r) begin
          state_nxt_s = ST_PLL_WAIT;
          tmr_load_s  = 1'b1;
          tmr_val_s   = PLL_LOAD;
        end else begin
          state_nxt_s = ST_APPLY;
        end
      end
      ST_PLL_WAIT: begin
        if (tmr_done_s) begin
          state_nxt_s = ST_APPLY;
        end else begin
          state_nxt_s = ST_PLL_WAIT;
        end
      end
      ST_APPLY: begin
        cfg_nxt_s   = tgt_r;
        state_nxt_s = ST_IDLE;
      end
      ST_RES_HOLD: begin
        if (tmr_value_s == '0) begin
          cfg_nxt_s      = 7'h00;
          chip_res_nxt_s = 1'b0;
          state_nxt_s    = ST_IDLE;
        end else begin
          state_nxt_s = ST_RES_HOLD;
        end
      end
      default: begin
        state_nxt_s    = ST_IDLE;
        cfg_nxt_s      = 7'h00;
        chip_res_nxt_s = 1'b0;
      end
    endcase
  end

  // State, outputs and pending-write buffer registers.
  always_ff @(posedge clk_in or posedge res) begin
    if (res) begin
      state_r      <= ST_IDLE;
      cfg_r        <= 7'h00;
      tgt_r        <= 7'h00;
      pll_after_r  <= 1'b0;
      chip_res_r   <= 1'b0;
      busy_r       <= 1'b0;
      clk_reg_r    <= 8'h00;
      pend_valid_r <= 1'b0;
      pend_data_r  <= 8'h00;
    end else begin
      state_r      <= state_nxt_s;
      cfg_r        <= cfg_nxt_s;
      tgt_r        <= tgt_nxt_s;
      pll_after_r  <= pll_after_nxt_s;
      chip_res_r   <= chip_res_nxt_s;
      busy_r       <= (state_nxt_s != ST_IDLE);
      clk_reg_r    <= accept_s ? {1'b0, wdata[6:0]} : clk_reg_r;
      pend_valid_r <= pend_valid_nxt_s;
      pend_data_r  <= accept_s ? wdata : pend_data_r;
    end
  end

  assign cfg      = cfg_r;
  assign chip_res = chip_res_r;
  assign busy     = busy_r;
  assign clk_reg  = clk_reg_r;

endmodule

// File: tb/tb_clk_cfg_sequencer.sv
// Directed self-checking bench for clk_cfg_sequencer with 16-cycle settle waits.
module tb_clk_cfg_sequencer;

  logic       clk_in = 1'b0;
  logic       res    = 1'b1;
  logic       wr     = 1'b0;
  logic [7:0] wdata  = 8'h00;
  logic [6:0] cfg;
  logic       chip_res, busy;
  logic [7:0] clk_reg;
  int         total = 0;
  int         bad   = 0;

  clk_cfg_sequencer #(
    .OSC_SETTLE (16),
    .PLL_SETTLE (16),
    .RES_HOLD   (16),
    .CNT_W      (20)
  ) dut (
    .clk_in   (clk_in),
    .res      (res),
    .wr       (wr),
    .wdata    (wdata),
    .cfg      (cfg),
    .chip_res (chip_res),
    .busy     (busy),
    .clk_reg  (clk_reg)
  );

  always #5 clk_in = ~clk_in;

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic write(input logic [7:0] d);
    wr    = 1'b1;
    wdata = d;
    tick();
    wr    = 1'b0;
  endtask

  task automatic test_reset();
    #2;
    total++;
    if ({cfg, chip_res, busy, clk_reg} !== {7'h00, 1'b0, 1'b0, 8'h00}) begin
      bad++;
      $display("FAIL reset_state: cfg=%h chip_res=%b busy=%b clk_reg=%h, want 00 0 0 00", cfg, chip_res, busy, clk_reg);
    end
    tick();
    tick();
    res = 1'b0;
    tick();
  endtask

  task automatic test_illegal_sel();
    write(8'h02);
    total++;
    if ({cfg, busy, clk_reg} !== {7'h00, 1'b0, 8'h02}) begin
      bad++;
      $display("FAIL illegal_sel: cfg=%h busy=%b clk_reg=%h, want 00 0 02", cfg, busy, clk_reg);
    end
    write(8'h01);
    total++;
    if ({cfg, busy} !== {7'h01, 1'b0}) begin
      bad++;
      $display("FAIL direct_sel: cfg=%h busy=%b, want 01 0", cfg, busy);
    end
    write(8'h00);
  endtask

  task automatic test_rise_seq();
    logic hold_ok;
    write(8'h6F);
    total++;
    if ({cfg, busy} !== {7'h68, 1'b1}) begin
      bad++;
      $display("FAIL rise_first: cfg=%h busy=%b, want 68 1", cfg, busy);
    end
    hold_ok = 1'b1;
    for (int i = 0; i < 32; i++) begin
      tick();
      if ({cfg, busy} !== {7'h68, 1'b1}) hold_ok = 1'b0;
    end
    total++;
    if (hold_ok !== 1'b1) begin
      bad++;
      $display("FAIL rise_hold: cfg=%h busy=%b, want 68 1 for 32 cycles", cfg, busy);
    end
    tick();
    total++;
    if ({cfg, busy, clk_reg} !== {7'h6F, 1'b0, 8'h6F}) begin
      bad++;
      $display("FAIL rise_apply: cfg=%h busy=%b clk_reg=%h, want 6F 0 6F", cfg, busy, clk_reg);
    end
  endtask

  task automatic test_fall();
    logic safe;
    write(8'h01);
    safe = !(cfg[2:0] >= 3'd3 && !cfg[6]);
    total++;
    if ({cfg, busy} !== {7'h69, 1'b1}) begin
      bad++;
      $display("FAIL fall_first: cfg=%h busy=%b, want 69 1", cfg, busy);
    end
    tick();
    safe = safe && !(cfg[2:0] >= 3'd3 && !cfg[6]);
    total++;
    if ({cfg, busy} !== {7'h01, 1'b0}) begin
      bad++;
      $display("FAIL fall_apply: cfg=%h busy=%b, want 01 0", cfg, busy);
    end
    total++;
    if (safe !== 1'b1) begin
      bad++;
      $display("FAIL fall_safe: pll select seen with PLLENA=0, got %b want 1", safe);
    end
  endtask

  task automatic test_pending();
    write(8'h6F);
    tick();
    tick();
    write(8'h6E);
    write(8'h6D);
    total++;
    if ({clk_reg, busy} !== {8'h6D, 1'b1}) begin
      bad++;
      $display("FAIL pend_clk_reg: clk_reg=%h busy=%b, want 6D 1", clk_reg, busy);
    end
    for (int i = 0; i < 29; i++) tick();
    total++;
    if ({cfg, busy} !== {7'h6F, 1'b0}) begin
      bad++;
      $display("FAIL pend_seq_end: cfg=%h busy=%b, want 6F 0", cfg, busy);
    end
    tick();
    total++;
    if ({cfg, busy} !== {7'h6D, 1'b0}) begin
      bad++;
      $display("FAIL pend_apply: cfg=%h busy=%b, want 6D 0", cfg, busy);
    end
    tick();
    tick();
    total++;
    if ({cfg, busy, clk_reg} !== {7'h6D, 1'b0, 8'h6D}) begin
      bad++;
      $display("FAIL pend_no_settle: cfg=%h busy=%b clk_reg=%h, want 6D 0 6D", cfg, busy, clk_reg);
    end
  endtask

  task automatic test_chip_reset();
    int hi;
    write(8'h80);
    total++;
    if ({chip_res, busy} !== {1'b1, 1'b1}) begin
      bad++;
      $display("FAIL res_start: chip_res=%b busy=%b, want 1 1", chip_res, busy);
    end
    hi = 0;
    while (chip_res === 1'b1 && hi < 40) begin
      hi++;
      if (hi == 5) begin
        wr    = 1'b1;
        wdata = 8'h6F;
      end
      tick();
      wr = 1'b0;
    end
    total++;
    if (hi !== 16) begin
      bad++;
      $display("FAIL res_len: chip_res high %0d cycles, want 16", hi);
    end
    total++;
    if ({cfg, busy, clk_reg} !== {7'h00, 1'b0, 8'h00}) begin
      bad++;
      $display("FAIL res_end: cfg=%h busy=%b clk_reg=%h, want 00 0 00", cfg, busy, clk_reg);
    end
    for (int i = 0; i < 3; i++) tick();
    total++;
    if ({cfg, busy, chip_res} !== {7'h00, 1'b0, 1'b0}) begin
      bad++;
      $display("FAIL res_ignore: cfg=%h busy=%b chip_res=%b, want 00 0 0", cfg, busy, chip_res);
    end
  endtask

  task automatic test_async_reset();
    write(8'h6F);
    tick();
    tick();
    write(8'h01);
    total++;
    if ({cfg, busy} !== {7'h68, 1'b1}) begin
      bad++;
      $display("FAIL ares_pre: cfg=%h busy=%b, want 68 1", cfg, busy);
    end
    #3;
    res = 1'b1;
    #1;
    total++;
    if ({cfg, chip_res, busy, clk_reg} !== {7'h00, 1'b0, 1'b0, 8'h00}) begin
      bad++;
      $display("FAIL ares_now: cfg=%h chip_res=%b busy=%b clk_reg=%h, want 00 0 0 00", cfg, chip_res, busy, clk_reg);
    end
    tick();
    res = 1'b0;
    for (int i = 0; i < 40; i++) tick();
    total++;
    if ({cfg, busy, clk_reg} !== {7'h00, 1'b0, 8'h00}) begin
      bad++;
      $display("FAIL ares_after: cfg=%h busy=%b clk_reg=%h, want 00 0 00", cfg, busy, clk_reg);
    end
  endtask

  initial begin
    test_reset();
    test_illegal_sel();
    test_rise_seq();
    test_fall();
    test_pending();
    test_chip_reset();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
